d_reg_pipe: RTL

Parametrised D-register pipeline: WIDTH-bit data passes through DEPTH clocked stages, each carrying a valid bit. A global enable stalls the whole chain, flush clears it, and a registered occupancy count reports how many stages hold valid data. It is the clocked, multi-stage successor to the level-sensitive D latch with reset, and it keeps the same q / q_not output pair. Used as a delay-matching pipeline wherever a data path must be retimed by a fixed number of enabled cycles.

---
 rtl/d_reg_pipe.sv | 66 ++++++
 1 files changed

// File: rtl/d_reg_pipe.sv
// d_reg_pipe: fixed-latency D-register delay line.
// WIDTH-bit words ride through DEPTH enabled stages, each stage tagged with a
// valid bit. enable stalls the whole chain, flush empties it, and occupancy is
// a registered count of the stages currently holding valid data.
//
// Handshake: d_valid qualifies d at every edge where enable=1 and neither
// reset nor flush is high. There is no ready; the source must hold its word
// while enable=0, because nothing is captured on a stalled edge. q_valid marks
// q as meaningful. q changes only at an enabled, reset or flush edge.
module d_reg_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       flush,
   input  logic                       d_valid,
   input  logic [WIDTH-1:0]           d,
   output logic                       q_valid,
   output logic [WIDTH-1:0]           q,
   output logic [WIDTH-1:0]           q_not,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] data_r [DEPTH];
   logic [DEPTH-1:0] valid_r;
   logic [OCC_W-1:0] occ_r;
   logic [OCC_W-1:0] occ_next;

   // Next occupancy: one word may enter and one may leave per enabled edge.
   // Modulo arithmetic is safe because the result always equals the number of
   // set valid bits, which lies in 0..DEPTH.
   always_comb begin
      occ_next = occ_r + OCC_W'(d_valid) - OCC_W'(valid_r[DEPTH-1]);
   end

   // Stage registers: reset beats flush beats enable; otherwise hold.
   // Bubbles load zero data so an empty stage always reads as 0.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_r[i] <= '0;
         end
         valid_r <= '0;
         occ_r   <= '0;
      end else if (enable) begin
         data_r[0]  <= d_valid ? d : '0;
         valid_r[0] <= d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            data_r[i]  <= data_r[i-1];
            valid_r[i] <= valid_r[i-1];
         end
         occ_r <= occ_next;
      end
   end

   // Outputs come straight from the last stage, so q and q_not always agree.
   assign q_valid   = valid_r[DEPTH-1];
   assign q         = data_r[DEPTH-1];
   assign q_not     = ~data_r[DEPTH-1];
   assign occupancy = occ_r;

endmodule
